// File: rtl/e203_lsu_icb_arbt_pkg.sv
// Shared definitions for the LSU ICB arbiter: requester source ids and the
// default outstanding-command depth.
package e203_lsu_icb_arbt_pkg;

    typedef enum logic {
        ARBT_SRC_AGU  = 1'b0,
        ARBT_SRC_NICE = 1'b1
    } arbt_src_e;

    localparam int ARBT_OUTS_DEPTH = 2;

endpackage

// File: rtl/e203_lsu_arbt_ofifo.sv
// Small synchronous FIFO of 1-bit entries with full/empty flags; records
// which requester issued each outstanding command.
module e203_lsu_arbt_ofifo #(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  logic din,
    input  logic pop,
    output logic dout,
    output logic full,
    output logic empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [DEPTH-1:0] mem;
    logic [PW-1:0]    wptr;
    logic [PW-1:0]    rptr;
    logic [CW-1:0]    cnt;
    logic             push_ok;
    logic             pop_ok;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full    = (cnt == CW'(DEPTH));
    assign empty   = (cnt == '0);
    // A push into a full FIFO is refused even when a pop frees a slot this cycle.
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;
    assign dout    = mem[rptr];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            if (push_ok) begin
                wptr <= ptr_inc(wptr);
            end
            if (pop_ok) begin
                rptr <= ptr_inc(rptr);
            end
            case ({push_ok, pop_ok})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/e203_lsu_icb_arbt.sv
// Two-requester (AGU, NICE) ICB arbiter sharing one LSU master port, with
// in-order response routing. Define E203_LSU_ARBT_RR_EN for round-robin.
module e203_lsu_icb_arbt
    import e203_lsu_icb_arbt_pkg::*;
#(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int OUTS_DEPTH = ARBT_OUTS_DEPTH
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            nice_mem_holdup,
    output logic            arbt_active,

    input  logic            agu_icb_cmd_valid,
    output logic            agu_icb_cmd_ready,
    input  logic [AW-1:0]   agu_icb_cmd_addr,
    input  logic            agu_icb_cmd_read,
    input  logic [DW-1:0]   agu_icb_cmd_wdata,
    input  logic [DW/8-1:0] agu_icb_cmd_wmask,
    input  logic [1:0]      agu_icb_cmd_size,
    output logic            agu_icb_rsp_valid,
    input  logic            agu_icb_rsp_ready,
    output logic            agu_icb_rsp_err,
    output logic [DW-1:0]   agu_icb_rsp_rdata,

    input  logic            nice_icb_cmd_valid,
    output logic            nice_icb_cmd_ready,
    input  logic [AW-1:0]   nice_icb_cmd_addr,
    input  logic            nice_icb_cmd_read,
    input  logic [DW-1:0]   nice_icb_cmd_wdata,
    input  logic [DW/8-1:0] nice_icb_cmd_wmask,
    input  logic [1:0]      nice_icb_cmd_size,
    output logic            nice_icb_rsp_valid,
    input  logic            nice_icb_rsp_ready,
    output logic            nice_icb_rsp_err,
    output logic [DW-1:0]   nice_icb_rsp_rdata,

    output logic            lsu_icb_cmd_valid,
    input  logic            lsu_icb_cmd_ready,
    output logic [AW-1:0]   lsu_icb_cmd_addr,
    output logic            lsu_icb_cmd_read,
    output logic [DW-1:0]   lsu_icb_cmd_wdata,
    output logic [DW/8-1:0] lsu_icb_cmd_wmask,
    output logic [1:0]      lsu_icb_cmd_size,
    input  logic            lsu_icb_rsp_valid,
    output logic            lsu_icb_rsp_ready,
    input  logic            lsu_icb_rsp_err,
    input  logic [DW-1:0]   lsu_icb_rsp_rdata
);

    // Handshake rule on every channel: a beat transfers on a clock edge where
    // valid and ready are both high; a presented valid holds until it transfers.

    logic      agu_req;
    logic      nice_req;
    arbt_src_e grant_id;
    logic      grant_req;
    logic      sel_nice;
    logic      cmd_hsk;
    logic      lock_vld;
    arbt_src_e lock_id;
    logic      fifo_full;
    logic      fifo_empty;
    logic      fifo_dout;
    logic      rsp_sel_agu;
    logic      rsp_sel_nice;
    logic      rsp_hsk;

`ifdef E203_LSU_ARBT_RR_EN
    arbt_src_e rr_ptr;
`endif

    assign agu_req  = agu_icb_cmd_valid & ~nice_mem_holdup;
    assign nice_req = nice_icb_cmd_valid;

    // A locked grant keeps using the raw valid so a late holdup cannot
    // withdraw an AGU command that is already on the bus.
    always_comb begin
        grant_id  = ARBT_SRC_AGU;
        grant_req = 1'b0;
        if (lock_vld) begin
            grant_id  = lock_id;
            grant_req = (lock_id == ARBT_SRC_NICE) ? nice_icb_cmd_valid : agu_icb_cmd_valid;
        end else begin
`ifdef E203_LSU_ARBT_RR_EN
            if (agu_req & nice_req) begin
                grant_id = rr_ptr;
            end else if (nice_req) begin
                grant_id = ARBT_SRC_NICE;
            end
`else
            if (nice_req) begin
                grant_id = ARBT_SRC_NICE;
            end
`endif
            grant_req = agu_req | nice_req;
        end
    end

    assign sel_nice           = (grant_id == ARBT_SRC_NICE);
    assign lsu_icb_cmd_valid  = grant_req & ~fifo_full;
    assign cmd_hsk            = lsu_icb_cmd_valid & lsu_icb_cmd_ready;
    assign agu_icb_cmd_ready  = cmd_hsk & ~sel_nice;
    assign nice_icb_cmd_ready = cmd_hsk & sel_nice;

    assign lsu_icb_cmd_addr  = sel_nice ? nice_icb_cmd_addr  : agu_icb_cmd_addr;
    assign lsu_icb_cmd_read  = sel_nice ? nice_icb_cmd_read  : agu_icb_cmd_read;
    assign lsu_icb_cmd_wdata = sel_nice ? nice_icb_cmd_wdata : agu_icb_cmd_wdata;
    assign lsu_icb_cmd_wmask = sel_nice ? nice_icb_cmd_wmask : agu_icb_cmd_wmask;
    assign lsu_icb_cmd_size  = sel_nice ? nice_icb_cmd_size  : agu_icb_cmd_size;

    always_ff @(posedge clk) begin
        if (rst) begin
            lock_vld <= 1'b0;
            lock_id  <= ARBT_SRC_AGU;
        end else begin
            lock_vld <= grant_req & ~cmd_hsk;
            if (grant_req & ~cmd_hsk) begin
                lock_id <= grant_id;
            end
        end
    end

`ifdef E203_LSU_ARBT_RR_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= ARBT_SRC_AGU;
        end else if (cmd_hsk) begin
            rr_ptr <= sel_nice ? ARBT_SRC_AGU : ARBT_SRC_NICE;
        end
    end
`endif

    e203_lsu_arbt_ofifo #(
        .DEPTH (OUTS_DEPTH)
    ) u_ofifo (
        .clk   (clk),
        .rst   (rst),
        .push  (cmd_hsk),
        .din   (sel_nice),
        .pop   (rsp_hsk),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign rsp_sel_nice = ~fifo_empty & fifo_dout;
    assign rsp_sel_agu  = ~fifo_empty & ~fifo_dout;
    assign rsp_hsk      = lsu_icb_rsp_valid & lsu_icb_rsp_ready;

    assign agu_icb_rsp_valid  = lsu_icb_rsp_valid & rsp_sel_agu;
    assign nice_icb_rsp_valid = lsu_icb_rsp_valid & rsp_sel_nice;
    assign lsu_icb_rsp_ready  = (rsp_sel_agu & agu_icb_rsp_ready) | (rsp_sel_nice & nice_icb_rsp_ready);
    assign agu_icb_rsp_err    = lsu_icb_rsp_err;
    assign agu_icb_rsp_rdata  = lsu_icb_rsp_rdata;
    assign nice_icb_rsp_err   = lsu_icb_rsp_err;
    assign nice_icb_rsp_rdata = lsu_icb_rsp_rdata;

    assign arbt_active = agu_icb_cmd_valid | nice_icb_cmd_valid | ~fifo_empty;

    // A response with nothing outstanding has no owner to route to.
    a_rsp_when_empty: assert property (@(posedge clk) disable iff (rst)
        !(lsu_icb_rsp_valid && fifo_empty));

endmodule

// File: tb/tb_e203_lsu_icb_arbt.sv
// Directed bench for e203_lsu_icb_arbt: a queue-based outstanding model checked
// every cycle, plus literal expectations for each scenario.
module tb_e203_lsu_icb_arbt;

  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int OUTS = 2;

  logic            clk;
  logic            rst;
  logic            nice_mem_holdup;
  logic            arbt_active;
  logic            agu_icb_cmd_valid, agu_icb_cmd_ready;
  logic [AW-1:0]   agu_icb_cmd_addr;
  logic            agu_icb_cmd_read;
  logic [DW-1:0]   agu_icb_cmd_wdata;
  logic [DW/8-1:0] agu_icb_cmd_wmask;
  logic [1:0]      agu_icb_cmd_size;
  logic            agu_icb_rsp_valid, agu_icb_rsp_ready, agu_icb_rsp_err;
  logic [DW-1:0]   agu_icb_rsp_rdata;
  logic            nice_icb_cmd_valid, nice_icb_cmd_ready;
  logic [AW-1:0]   nice_icb_cmd_addr;
  logic            nice_icb_cmd_read;
  logic [DW-1:0]   nice_icb_cmd_wdata;
  logic [DW/8-1:0] nice_icb_cmd_wmask;
  logic [1:0]      nice_icb_cmd_size;
  logic            nice_icb_rsp_valid, nice_icb_rsp_ready, nice_icb_rsp_err;
  logic [DW-1:0]   nice_icb_rsp_rdata;
  logic            lsu_icb_cmd_valid, lsu_icb_cmd_ready;
  logic [AW-1:0]   lsu_icb_cmd_addr;
  logic            lsu_icb_cmd_read;
  logic [DW-1:0]   lsu_icb_cmd_wdata;
  logic [DW/8-1:0] lsu_icb_cmd_wmask;
  logic [1:0]      lsu_icb_cmd_size;
  logic            lsu_icb_rsp_valid, lsu_icb_rsp_ready, lsu_icb_rsp_err;
  logic [DW-1:0]   lsu_icb_rsp_rdata;

  int checks   = 0;
  int failures = 0;

  e203_lsu_icb_arbt #(.AW(AW), .DW(DW), .OUTS_DEPTH(OUTS)) dut (
    .clk                (clk),
    .rst                (rst),
    .nice_mem_holdup    (nice_mem_holdup),
    .arbt_active        (arbt_active),
    .agu_icb_cmd_valid  (agu_icb_cmd_valid),
    .agu_icb_cmd_ready  (agu_icb_cmd_ready),
    .agu_icb_cmd_addr   (agu_icb_cmd_addr),
    .agu_icb_cmd_read   (agu_icb_cmd_read),
    .agu_icb_cmd_wdata  (agu_icb_cmd_wdata),
    .agu_icb_cmd_wmask  (agu_icb_cmd_wmask),
    .agu_icb_cmd_size   (agu_icb_cmd_size),
    .agu_icb_rsp_valid  (agu_icb_rsp_valid),
    .agu_icb_rsp_ready  (agu_icb_rsp_ready),
    .agu_icb_rsp_err    (agu_icb_rsp_err),
    .agu_icb_rsp_rdata  (agu_icb_rsp_rdata),
    .nice_icb_cmd_valid (nice_icb_cmd_valid),
    .nice_icb_cmd_ready (nice_icb_cmd_ready),
    .nice_icb_cmd_addr  (nice_icb_cmd_addr),
    .nice_icb_cmd_read  (nice_icb_cmd_read),
    .nice_icb_cmd_wdata (nice_icb_cmd_wdata),
    .nice_icb_cmd_wmask (nice_icb_cmd_wmask),
    .nice_icb_cmd_size  (nice_icb_cmd_size),
    .nice_icb_rsp_valid (nice_icb_rsp_valid),
    .nice_icb_rsp_ready (nice_icb_rsp_ready),
    .nice_icb_rsp_err   (nice_icb_rsp_err),
    .nice_icb_rsp_rdata (nice_icb_rsp_rdata),
    .lsu_icb_cmd_valid  (lsu_icb_cmd_valid),
    .lsu_icb_cmd_ready  (lsu_icb_cmd_ready),
    .lsu_icb_cmd_addr   (lsu_icb_cmd_addr),
    .lsu_icb_cmd_read   (lsu_icb_cmd_read),
    .lsu_icb_cmd_wdata  (lsu_icb_cmd_wdata),
    .lsu_icb_cmd_wmask  (lsu_icb_cmd_wmask),
    .lsu_icb_cmd_size   (lsu_icb_cmd_size),
    .lsu_icb_rsp_valid  (lsu_icb_rsp_valid),
    .lsu_icb_rsp_ready  (lsu_icb_rsp_ready),
    .lsu_icb_rsp_err    (lsu_icb_rsp_err),
    .lsu_icb_rsp_rdata  (lsu_icb_rsp_rdata)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0b expected=%0b", name, act, exp);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%08h expected=%08h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    nice_mem_holdup    = 1'b0;
    agu_icb_cmd_valid  = 1'b0;
    agu_icb_cmd_addr   = '0;
    agu_icb_cmd_read   = 1'b0;
    agu_icb_cmd_wdata  = '0;
    agu_icb_cmd_wmask  = '0;
    agu_icb_cmd_size   = '0;
    agu_icb_rsp_ready  = 1'b1;
    nice_icb_cmd_valid = 1'b0;
    nice_icb_cmd_addr  = '0;
    nice_icb_cmd_read  = 1'b0;
    nice_icb_cmd_wdata = '0;
    nice_icb_cmd_wmask = '0;
    nice_icb_cmd_size  = '0;
    nice_icb_rsp_ready = 1'b1;
    lsu_icb_cmd_ready  = 1'b1;
    lsu_icb_rsp_valid  = 1'b0;
    lsu_icb_rsp_err    = 1'b0;
    lsu_icb_rsp_rdata  = '0;
  endtask

  task automatic agu_cmd(input logic v, input logic [31:0] a, input logic rd);
    agu_icb_cmd_valid = v;
    agu_icb_cmd_addr  = a;
    agu_icb_cmd_read  = rd;
    agu_icb_cmd_wdata = a ^ 32'h5555_5555;
    agu_icb_cmd_wmask = 4'hf;
    agu_icb_cmd_size  = 2'd2;
  endtask

  task automatic nice_cmd(input logic v, input logic [31:0] a, input logic rd);
    nice_icb_cmd_valid = v;
    nice_icb_cmd_addr  = a;
    nice_icb_cmd_read  = rd;
    nice_icb_cmd_wdata = a ^ 32'hAAAA_0000;
    nice_icb_cmd_wmask = 4'h3;
    nice_icb_cmd_size  = 2'd1;
  endtask

  // scoreboard: exp_q holds the source id of every accepted, unanswered command
  logic [0:0] exp_q[$];
  int         pend = -1;
  int         win;
  logic       wreq, m_full, e_lv, e_hsk, e_lrr, e_head_ok;
  logic [0:0] head;

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      pend = -1;
    end else begin
      if (pend == 0) begin
        win = 0; wreq = agu_icb_cmd_valid;
      end else if (pend == 1) begin
        win = 1; wreq = nice_icb_cmd_valid;
      end else if (nice_icb_cmd_valid) begin
        win = 1; wreq = 1'b1;
      end else if (agu_icb_cmd_valid && !nice_mem_holdup) begin
        win = 0; wreq = 1'b1;
      end else begin
        win = -1; wreq = 1'b0;
      end
      m_full    = (exp_q.size() == OUTS);
      e_lv      = wreq && !m_full;
      e_hsk     = e_lv && lsu_icb_cmd_ready;
      e_head_ok = (exp_q.size() > 0);
      head      = e_head_ok ? exp_q[0] : 1'b0;
      e_lrr     = e_head_ok && (head == 1'b1 ? nice_icb_rsp_ready : agu_icb_rsp_ready);

      chk1("m_lsu_cmd_valid", lsu_icb_cmd_valid, e_lv);
      chk1("m_agu_cmd_ready", agu_icb_cmd_ready, e_hsk && win == 0);
      chk1("m_nice_cmd_ready", nice_icb_cmd_ready, e_hsk && win == 1);
      if (e_lv) begin
        if (win == 1) begin
          chk32("m_cmd_addr", lsu_icb_cmd_addr, nice_icb_cmd_addr);
          chk32("m_cmd_wdata", lsu_icb_cmd_wdata, nice_icb_cmd_wdata);
          chk32("m_cmd_misc", {25'd0, lsu_icb_cmd_read, lsu_icb_cmd_wmask, lsu_icb_cmd_size},
                {25'd0, nice_icb_cmd_read, nice_icb_cmd_wmask, nice_icb_cmd_size});
        end else begin
          chk32("m_cmd_addr", lsu_icb_cmd_addr, agu_icb_cmd_addr);
          chk32("m_cmd_wdata", lsu_icb_cmd_wdata, agu_icb_cmd_wdata);
          chk32("m_cmd_misc", {25'd0, lsu_icb_cmd_read, lsu_icb_cmd_wmask, lsu_icb_cmd_size},
                {25'd0, agu_icb_cmd_read, agu_icb_cmd_wmask, agu_icb_cmd_size});
        end
      end
      chk1("m_agu_rsp_valid", agu_icb_rsp_valid, lsu_icb_rsp_valid && e_head_ok && head == 1'b0);
      chk1("m_nice_rsp_valid", nice_icb_rsp_valid, lsu_icb_rsp_valid && e_head_ok && head == 1'b1);
      chk1("m_lsu_rsp_ready", lsu_icb_rsp_ready, e_lrr);
      chk1("m_arbt_active", arbt_active, agu_icb_cmd_valid || nice_icb_cmd_valid || e_head_ok);
      chk32("m_agu_rdata", agu_icb_rsp_rdata, lsu_icb_rsp_rdata);
      chk32("m_nice_rdata", nice_icb_rsp_rdata, lsu_icb_rsp_rdata);
      chk1("m_agu_err", agu_icb_rsp_err, lsu_icb_rsp_err);
      chk1("m_nice_err", nice_icb_rsp_err, lsu_icb_rsp_err);

      if (lsu_icb_rsp_valid && e_lrr) void'(exp_q.pop_front());
      if (e_hsk) exp_q.push_back((win == 1) ? 1'b1 : 1'b0);
      pend = (wreq && !e_hsk) ? win : -1;
    end
  end

  // directed stimulus with literal expectations
  initial begin
    rst = 1'b1;
    idle_all();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk1("rst_lsu_cmd_valid", lsu_icb_cmd_valid, 1'b0);
    chk1("rst_agu_cmd_ready", agu_icb_cmd_ready, 1'b0);
    chk1("rst_lsu_rsp_ready", lsu_icb_rsp_ready, 1'b0);
    chk1("rst_active", arbt_active, 1'b0);

    // single AGU read
    next_cycle();
    agu_cmd(1'b1, 32'h8000_0010, 1'b1);
    @(negedge clk);
    chk1("t1_lsu_valid", lsu_icb_cmd_valid, 1'b1);
    chk32("t1_addr", lsu_icb_cmd_addr, 32'h8000_0010);
    chk1("t1_read", lsu_icb_cmd_read, 1'b1);
    chk1("t1_agu_rdy", agu_icb_cmd_ready, 1'b1);
    chk1("t1_nice_rdy", nice_icb_cmd_ready, 1'b0);
    next_cycle();
    agu_cmd(1'b0, 32'h0, 1'b0);
    lsu_icb_rsp_valid = 1'b1;
    lsu_icb_rsp_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    chk1("t1_agu_rsp_valid", agu_icb_rsp_valid, 1'b1);
    chk1("t1_nice_rsp_valid", nice_icb_rsp_valid, 1'b0);
    chk32("t1_agu_rdata", agu_icb_rsp_rdata, 32'hDEAD_BEEF);
    chk1("t1_active_busy", arbt_active, 1'b1);
    next_cycle();
    lsu_icb_rsp_valid = 1'b0;
    @(negedge clk);
    chk1("t1_active_drop", arbt_active, 1'b0);

    // simultaneous requests: NICE first, then AGU; responses in order
    next_cycle();
    agu_cmd(1'b1, 32'h0000_0100, 1'b0);
    nice_cmd(1'b1, 32'h0000_0200, 1'b1);
    @(negedge clk);
    chk32("t2_first_addr", lsu_icb_cmd_addr, 32'h0000_0200);
    chk1("t2_first_nice_rdy", nice_icb_cmd_ready, 1'b1);
    chk1("t2_first_agu_rdy", agu_icb_cmd_ready, 1'b0);
    next_cycle();
    nice_cmd(1'b0, 32'h0, 1'b0);
    @(negedge clk);
    chk32("t2_second_addr", lsu_icb_cmd_addr, 32'h0000_0100);
    chk1("t2_second_agu_rdy", agu_icb_cmd_ready, 1'b1);
    next_cycle();
    agu_cmd(1'b0, 32'h0, 1'b0);
    lsu_icb_rsp_valid = 1'b1;
    lsu_icb_rsp_rdata = 32'h0000_0011;
    @(negedge clk);
    chk1("t2_rsp1_nice", nice_icb_rsp_valid, 1'b1);
    chk1("t2_rsp1_agu", agu_icb_rsp_valid, 1'b0);
    next_cycle();
    lsu_icb_rsp_rdata = 32'h0000_0022;
    lsu_icb_rsp_err   = 1'b1;
    @(negedge clk);
    chk1("t2_rsp2_agu", agu_icb_rsp_valid, 1'b1);
    chk1("t2_rsp2_err", agu_icb_rsp_err, 1'b1);
    next_cycle();
    lsu_icb_rsp_valid = 1'b0;
    lsu_icb_rsp_err   = 1'b0;

    // grant lock: AGU stalled, NICE arrives, holdup rises during the lock
    next_cycle();
    lsu_icb_cmd_ready = 1'b0;
    agu_cmd(1'b1, 32'h0000_0300, 1'b1);
    @(negedge clk);
    chk1("t3_c1_valid", lsu_icb_cmd_valid, 1'b1);
    next_cycle();
    nice_cmd(1'b1, 32'h0000_0400, 1'b0);
    @(negedge clk);
    chk32("t3_c2_addr", lsu_icb_cmd_addr, 32'h0000_0300);
    chk1("t3_c2_nice_rdy", nice_icb_cmd_ready, 1'b0);
    next_cycle();
    nice_mem_holdup = 1'b1;
    @(negedge clk);
    chk1("t3_c3_valid", lsu_icb_cmd_valid, 1'b1);
    chk32("t3_c3_addr", lsu_icb_cmd_addr, 32'h0000_0300);
    next_cycle();
    lsu_icb_cmd_ready = 1'b1;
    @(negedge clk);
    chk1("t3_hsk_agu_rdy", agu_icb_cmd_ready, 1'b1);
    chk1("t3_hsk_nice_rdy", nice_icb_cmd_ready, 1'b0);
    next_cycle();
    agu_cmd(1'b0, 32'h0, 1'b0);
    nice_mem_holdup = 1'b0;
    @(negedge clk);
    chk32("t3_nice_addr", lsu_icb_cmd_addr, 32'h0000_0400);
    chk1("t3_nice_rdy", nice_icb_cmd_ready, 1'b1);
    next_cycle();
    nice_cmd(1'b0, 32'h0, 1'b0);
    lsu_icb_rsp_valid = 1'b1;
    @(negedge clk);
    chk1("t3_rsp1_agu", agu_icb_rsp_valid, 1'b1);
    next_cycle();
    @(negedge clk);
    chk1("t3_rsp2_nice", nice_icb_rsp_valid, 1'b1);
    next_cycle();
    lsu_icb_rsp_valid = 1'b0;

    // FIFO full: two outstanding, third blocked until the first pop
    next_cycle();
    agu_cmd(1'b1, 32'h0000_0500, 1'b1);
    next_cycle();
    agu_cmd(1'b0, 32'h0, 1'b0);
    nice_cmd(1'b1, 32'h0000_0600, 1'b1);
    next_cycle();
    nice_cmd(1'b0, 32'h0, 1'b0);
    agu_cmd(1'b1, 32'h0000_0700, 1'b1);
    @(negedge clk);
    chk1("t4_full_valid", lsu_icb_cmd_valid, 1'b0);
    chk1("t4_full_agu_rdy", agu_icb_cmd_ready, 1'b0);
    next_cycle();
    lsu_icb_rsp_valid = 1'b1;
    lsu_icb_rsp_rdata = 32'h0000_00A1;
    @(negedge clk);
    chk1("t4_pop1_agu_rsp", agu_icb_rsp_valid, 1'b1);
    chk1("t4_pop1_push_blocked", agu_icb_cmd_ready, 1'b0);
    next_cycle();
    lsu_icb_rsp_rdata = 32'h0000_00A2;
    @(negedge clk);
    chk1("t4_pop2_nice_rsp", nice_icb_rsp_valid, 1'b1);
    chk1("t4_third_agu_rdy", agu_icb_cmd_ready, 1'b1);
    next_cycle();
    agu_cmd(1'b0, 32'h0, 1'b0);
    lsu_icb_rsp_rdata = 32'h0000_00A3;
    @(negedge clk);
    chk1("t4_pop3_agu_rsp", agu_icb_rsp_valid, 1'b1);
    next_cycle();
    lsu_icb_rsp_valid = 1'b0;

    // holdup masks AGU; release issues in the same cycle
    next_cycle();
    nice_mem_holdup = 1'b1;
    agu_cmd(1'b1, 32'h0000_0800, 1'b0);
    @(negedge clk);
    chk1("t5_masked_valid", lsu_icb_cmd_valid, 1'b0);
    chk1("t5_masked_rdy", agu_icb_cmd_ready, 1'b0);
    chk1("t5_active", arbt_active, 1'b1);
    next_cycle();
    nice_mem_holdup = 1'b0;
    @(negedge clk);
    chk1("t5_release_valid", lsu_icb_cmd_valid, 1'b1);
    chk32("t5_release_addr", lsu_icb_cmd_addr, 32'h0000_0800);
    next_cycle();
    agu_cmd(1'b0, 32'h0, 1'b0);
    lsu_icb_rsp_valid = 1'b1;
    @(negedge clk);
    chk1("t5_rsp_agu", agu_icb_rsp_valid, 1'b1);
    next_cycle();
    lsu_icb_rsp_valid = 1'b0;

    // reset with two outstanding commands
    next_cycle();
    agu_cmd(1'b1, 32'h0000_0900, 1'b1);
    nice_cmd(1'b1, 32'h0000_0A00, 1'b1);
    next_cycle();
    nice_cmd(1'b0, 32'h0, 1'b0);
    next_cycle();
    agu_cmd(1'b0, 32'h0, 1'b0);
    @(negedge clk);
    chk1("t6_pre_rsp_ready", lsu_icb_rsp_ready, 1'b1);
    next_cycle();
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    chk1("t6_rsp_ready", lsu_icb_rsp_ready, 1'b0);
    chk1("t6_active", arbt_active, 1'b0);
    chk1("t6_agu_rsp_valid", agu_icb_rsp_valid, 1'b0);
    chk1("t6_nice_rsp_valid", nice_icb_rsp_valid, 1'b0);

    repeat (3) next_cycle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/e203_lsu_icb_arbt.md
Name: e203_lsu_icb_arbt

Overview:
- Two-requester ICB arbiter in front of the LSU control path.
- Shares one downstream ICB master port between the AGU requester (port 0) and the NICE memory requester (port 1).
- Tracks outstanding commands in a small ordered FIFO and routes each response back to the requester that issued it.
- Provides an activity flag for clock gating.

Parameters:
- AW, 32, address width.
- DW, 32, data width; wmask width is DW/8.
- OUTS_DEPTH, 2, maximum outstanding commands; power of 2, minimum 1.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- nice_mem_holdup  in  1  when high, the AGU requester is masked from arbitration.
- arbt_active  out  1  high when any command is valid or the outstanding FIFO is non-empty.
- agu_icb_cmd_valid/ready  in/out  1  AGU command handshake.
- agu_icb_cmd_addr  in  AW  AGU command address.
- agu_icb_cmd_read  in  1  AGU read (1) or write (0).
- agu_icb_cmd_wdata  in  DW  AGU write data.
- agu_icb_cmd_wmask  in  DW/8  AGU write byte mask.
- agu_icb_cmd_size  in  2  AGU access size.
- agu_icb_rsp_valid/ready  out/in  1  AGU response handshake.
- agu_icb_rsp_err  out  1  AGU response error.
- agu_icb_rsp_rdata  out  DW  AGU response read data.
- nice_icb_*  same directions and widths as the agu_icb_* group; NICE requester.
- lsu_icb_cmd_valid/ready  out/in  1  downstream command handshake.
- lsu_icb_cmd_addr/read/wdata/wmask/size  out  as above  muxed command payload.
- lsu_icb_rsp_valid/ready  in/out  1  downstream response handshake.
- lsu_icb_rsp_err  in  1  downstream response error.
- lsu_icb_rsp_rdata  in  DW  downstream response read data.

Behaviour:
- Reset: all FIFO state cleared (empty), grant lock cleared, round-robin pointer set to AGU.
  - Consequences: lsu_icb_cmd_valid=0, both *_cmd_ready=0 unless a valid is present, all *_rsp_valid=0, arbt_active=0.
- Request mask: agu_req = agu_icb_cmd_valid & ~nice_mem_holdup; nice_req = nice_icb_cmd_valid.
- Arbitration is combinational with zero latency.
  - The command payload is muxed from the granted requester.
  - lsu_icb_cmd_valid = granted requester's req & ~fifo_full.
  - Only the granted requester's cmd_ready = lsu_icb_cmd_ready & ~fifo_full; the other requester's cmd_ready = 0.
- Fixed priority (default build): NICE wins when both request.
- Grant lock:
  - If the granted command is valid but not accepted (lsu_icb_cmd_ready=0 or FIFO full), a lock register holds that grant on the following cycles.
  - The lock releases on that requester's command handshake.
  - The grant never switches while a presented command is pending.
  - nice_mem_holdup rising while AGU is locked does not revoke the AGU grant.
- Outstanding FIFO: OUTS_DEPTH entries of 1-bit source id.
  - Push on downstream command handshake.
  - Pop on downstream response handshake.
  - Push is blocked when full, even if a pop occurs in the same cycle.
  - Push and pop in the same cycle when not full: occupancy unchanged.
  - Pointers wrap modulo OUTS_DEPTH.
- Response routing: while the FIFO is non-empty, lsu_icb_rsp_valid is forwarded to the requester named by the head id.
  - lsu_icb_rsp_ready = that requester's rsp_ready.
  - err and rdata are broadcast to both requesters; only the valid is qualified.
  - When the FIFO is empty, lsu_icb_rsp_ready=0 and both rsp_valid=0. A downstream rsp_valid while empty is a protocol error and is flagged by assertion.
- Responses are strictly in order; no reordering.
- Reset mid-transaction clears FIFO state immediately. Responses still in flight after reset are the system's responsibility.

Optional Feature:
- E203_LSU_ARBT_RR_EN defined: round-robin arbitration.
  - The pointer flips to the non-winning requester after every command handshake.
  - When both request, the requester named by the pointer wins.
  - The lock rules are unchanged.
- Undefined: fixed NICE-first priority and no pointer register.

Decomposition:
- Shared package/defines: source id constants ARBT_SRC_AGU=0, ARBT_SRC_NICE=1, plus the default OUTS_DEPTH.
- Sub-module e203_lsu_arbt_ofifo: parameterised 1-bit-wide sync FIFO with full/empty outputs, reused for the outstanding tracker.

Test Plan:
- Single AGU read, addr 0x8000_0010, lsu ready=1 -> lsu cmd in same cycle; response rdata 0xDEAD_BEEF routed to AGU only; FIFO returns to empty; arbt_active drops next cycle.
- AGU and NICE valid together, fixed priority -> NICE granted first; AGU granted next cycle. With RR_EN, two back-to-back pairs give order NICE, AGU, NICE, AGU when the pointer starts at AGU after the first NICE win.
- AGU valid with lsu_icb_cmd_ready=0 for 3 cycles, NICE raises valid in cycle 2 -> AGU stays granted through lock; NICE cmd_ready=0 until the AGU handshake.
- OUTS_DEPTH=2: issue 2 commands (AGU, NICE) with no responses -> third cmd_ready=0. Return responses in order -> first to AGU, second to NICE; the third command accepted after the first pop.
- nice_mem_holdup=1 with only AGU valid -> lsu_icb_cmd_valid=0; deasserting holdup -> AGU command issued that cycle.
- Reset asserted with 2 outstanding -> next cycle FIFO empty, rsp_valid=0 to both, lsu_icb_rsp_ready=0.
